// File: rtl/mem_responder.sv
// Word-array memory server with a val/rdy request channel, fixed-latency
// payload pipeline and an in-order response FIFO bounded by an outstanding count.
module mem_responder #(
  parameter int p_opaq_bits  = 8,
  parameter int p_num_words  = 256,
  parameter int p_latency    = 2,
  parameter int p_resp_depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [p_opaq_bits-1:0] req_opaque,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_data,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_op,
  output logic [p_opaq_bits-1:0] resp_opaque,
  output logic [31:0]            resp_addr,
  output logic [31:0]            resp_data
);

  localparam int IDX_W = $clog2(p_num_words);
  localparam int CNT_W = $clog2(p_resp_depth + 1);
  localparam int PTR_W = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
  localparam int PAY_W = 1 + p_opaq_bits + 64;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(p_resp_depth - 1)) return '0;
    else return p + PTR_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] occ;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [31:0]      mem [p_num_words];
  logic [PAY_W-1:0] fifo [p_resp_depth];
  logic [IDX_W-1:0] idx;
  logic             req_fire;
  logic             resp_fire;
  logic             push;
  logic [PAY_W-1:0] push_pay;
  logic [PAY_W-1:0] head;

  assign req_rdy   = !rst && (cnt < CNT_W'(p_resp_depth));
  assign req_fire  = req_val && req_rdy;
  assign resp_val  = (occ != '0);
  assign resp_fire = resp_val && resp_rdy;
  assign idx       = req_addr[2 +: IDX_W];

  // Stage p0: acceptance edge, array read sees all earlier writes
  logic             vld_p0;
  logic [PAY_W-1:0] pay_p0;
  assign vld_p0 = req_fire;
  assign pay_p0 = {req_op, req_opaque, req_addr, (req_op ? 32'd0 : mem[idx])};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < p_num_words; i++) mem[i] <= '0;
    end else if (req_fire && req_op) begin
      mem[idx] <= req_data;
    end
  end

  // Stages p1..p(latency-1): never stall, FIFO space is guaranteed by cnt
  generate
    if (p_latency == 1) begin : g_direct
      assign push     = vld_p0;
      assign push_pay = pay_p0;
    end else begin : g_pipe
      logic             vld_pn [p_latency-1];
      logic [PAY_W-1:0] pay_pn [p_latency-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < p_latency - 1; i++) vld_pn[i] <= 1'b0;
        end else begin
          vld_pn[0] <= vld_p0;
          for (int i = 1; i < p_latency - 1; i++) vld_pn[i] <= vld_pn[i-1];
        end
      end

      always_ff @(posedge clk) begin
        pay_pn[0] <= pay_p0;
        for (int i = 1; i < p_latency - 1; i++) pay_pn[i] <= pay_pn[i-1];
      end

      assign push     = vld_pn[p_latency-2];
      assign push_pay = pay_pn[p_latency-2];
    end
  endgenerate

  // Response FIFO: occupancy, not pointer equality, tells full from empty
  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= push_pay;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      cnt  <= '0;
    end else begin
      if (push)      wptr <= ptr_inc(wptr);
      if (resp_fire) rptr <= ptr_inc(rptr);
      case ({push, resp_fire})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
      case ({req_fire, resp_fire})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = fifo[rptr];
  assign {resp_op, resp_opaque, resp_addr, resp_data} = resp_val ? head : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: drivers push expected responses,
// a negedge monitor pops and compares them when a response fires.
module tb_mem_responder;

  localparam int OB  = 8;
  localparam int NW  = 256;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_val = 1'b0;
  logic          req_rdy;
  logic          req_op = 1'b0;
  logic [OB-1:0] req_opaque = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_data = '0;
  logic          resp_val;
  logic          resp_rdy = 1'b1;
  logic          resp_op;
  logic [OB-1:0] resp_opaque;
  logic [31:0]   resp_addr;
  logic [31:0]   resp_data;

  mem_responder #(
    .p_opaq_bits (OB),
    .p_num_words (NW),
    .p_latency   (LAT),
    .p_resp_depth(DEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_op     (req_op),
    .req_opaque (req_opaque),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_op    (resp_op),
    .resp_opaque(resp_opaque),
    .resp_addr  (resp_addr),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          op;
    logic [OB-1:0] opq;
    logic [31:0]   addr;
    logic [31:0]   data;
  } exp_t;

  exp_t        q[$];
  int          rcyc[$];
  logic [31:0] model [NW];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rcount = 0;
  logic [31:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && resp_val && resp_rdy) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got op=%0b opq=%h addr=%h data=%h, none expected",
                 resp_op, resp_opaque, resp_addr, resp_data);
      end else begin
        e = q.pop_front();
        if ({resp_op, resp_opaque, resp_addr, resp_data} !== {e.op, e.opq, e.addr, e.data}) begin
          errors++;
          $display("FAIL resp_fields got op=%0b opq=%h addr=%h data=%h, expected op=%0b opq=%h addr=%h data=%h",
                   resp_op, resp_opaque, resp_addr, resp_data, e.op, e.opq, e.addr, e.data);
        end
      end
      last_data = resp_data;
      rcount++;
      rcyc.push_back(cyc);
    end
  end

  task automatic clear_model();
    for (int i = 0; i < NW; i++) model[i] = '0;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic op, input logic [OB-1:0] opq, input logic [31:0] addr,
                      input logic [31:0] data);
    exp_t e;
    int   w = 0;
    int   ix;
    req_op = op; req_opaque = opq; req_addr = addr; req_data = data; req_val = 1'b1;
    while (!req_rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_rdy) begin
      checks++; errors++;
      $display("FAIL req_timeout got req_rdy=%0b after %0d cycles, expected 1", req_rdy, w);
      req_val = 1'b0;
      return;
    end
    ix = int'(addr[2 +: 8]);
    e.op = op; e.opq = opq; e.addr = addr; e.data = op ? 32'd0 : model[ix];
    if (op) model[ix] = data;
    q.push_back(e);
    @(negedge clk);
    req_val = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending, expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({req_rdy, resp_val, resp_op, resp_opaque, resp_addr, resp_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%0b val=%0b data=%h, expected all 0", req_rdy, resp_val, resp_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_after_reset got %0b expected 1", req_rdy);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    resp_rdy = 1'b1;
    send(1'b1, 8'h01, 32'h100, 32'hDEADBEEF);
    drain();
    send(1'b0, 8'h05, 32'h100, 32'h0);
    repeat (LAT - 2) @(negedge clk);
    checks++;
    if (resp_val !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got resp_val=%0b expected 0", resp_val);
    end
    @(negedge clk);
    checks++;
    if (resp_val !== 1'b1 || resp_data !== 32'hDEADBEEF || resp_opaque !== 8'h05) begin
      errors++;
      $display("FAIL latency_read got val=%0b data=%h opq=%h expected 1 deadbeef 05", resp_val, resp_data, resp_opaque);
    end
    drain();
  endtask

  task automatic test_stream();
    resp_rdy = 1'b1;
    rcyc.delete();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (req_rdy !== 1'b1) begin
        errors++;
        $display("FAIL stream_rdy req %0d got %0b expected 1", i, req_rdy);
      end
      send(1'b0, OB'(i), 32'h200 + 32'(i * 4), 32'h0);
    end
    drain();
    checks++;
    if (rcyc.size() != 8) begin
      errors++;
      $display("FAIL stream_count got %0d expected 8", rcyc.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (rcyc[i] != rcyc[i-1] + 1) begin
          errors++;
          $display("FAIL stream_gap resp %0d got cycle %0d expected %0d", i, rcyc[i], rcyc[i-1] + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int          acc = 0;
    int          r0;
    exp_t        e;
    logic [31:0] s_addr;
    logic [OB-1:0] s_opq;
    r0 = rcount;
    resp_rdy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_op = 1'b0; req_opaque = OB'(8'h10 + acc); req_addr = 32'(acc * 4); req_val = 1'b1;
      if (req_rdy) begin
        e.op = 1'b0; e.opq = OB'(8'h10 + acc); e.addr = 32'(acc * 4); e.data = model[acc];
        q.push_back(e);
        acc++;
      end
      @(negedge clk);
    end
    checks++;
    if (acc != DEP || req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got %0d accepted rdy=%0b expected %0d and 0", acc, req_rdy, DEP);
    end
    s_addr = resp_addr; s_opq = resp_opaque;
    repeat (3) @(negedge clk);
    checks++;
    if (resp_val !== 1'b1 || resp_addr !== s_addr || resp_opaque !== s_opq || s_opq !== 8'h10) begin
      errors++;
      $display("FAIL bp_stable got val=%0b opq=%h addr=%h expected 1 10 %h", resp_val, resp_opaque, resp_addr, s_addr);
    end
    resp_rdy = 1'b1;
    send(1'b0, 8'h14, 32'h10, 32'h0);
    send(1'b0, 8'h15, 32'h14, 32'h0);
    drain();
    checks++;
    if (rcount - r0 != 6) begin
      errors++;
      $display("FAIL bp_total got %0d responses expected 6", rcount - r0);
    end
  endtask

  task automatic test_alias();
    resp_rdy = 1'b1;
    send(1'b1, 8'h21, 32'h0, 32'h11);
    send(1'b1, 8'h22, 32'h400, 32'h22);
    send(1'b0, 8'h23, 32'h0, 32'h0);
    drain();
    checks++;
    if (last_data !== 32'h22) begin
      errors++;
      $display("FAIL alias_0 got %h expected 00000022", last_data);
    end
    send(1'b0, 8'h24, 32'h3, 32'h0);
    drain();
    checks++;
    if (last_data !== 32'h22) begin
      errors++;
      $display("FAIL alias_3 got %h expected 00000022", last_data);
    end
  endtask

  task automatic test_back_to_back();
    resp_rdy = 1'b1;
    send(1'b1, 8'h31, 32'h20, 32'hCAFE0123);
    send(1'b0, 8'h32, 32'h20, 32'h0);
    drain();
    checks++;
    if (last_data !== 32'hCAFE0123) begin
      errors++;
      $display("FAIL b2b_read got %h expected cafe0123", last_data);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    resp_rdy = 1'b0;
    send(1'b0, 8'h41, 32'h100, 32'h0);
    send(1'b0, 8'h42, 32'h20, 32'h0);
    send(1'b0, 8'h43, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    checks++;
    if (resp_val !== 1'b1) begin
      errors++;
      $display("FAIL mid_pending got resp_val=%0b expected 1", resp_val);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b0 || resp_data !== 32'h0 || resp_opaque !== '0) begin
      errors++;
      $display("FAIL mid_reset got val=%0b rdy=%0b data=%h opq=%h expected all 0", resp_val, req_rdy, resp_data, resp_opaque);
    end
    q.delete();
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    resp_rdy = 1'b1;
    r0 = rcount;
    repeat (6) @(negedge clk);
    checks++;
    if (rcount != r0) begin
      errors++;
      $display("FAIL stale_resp got %0d responses expected 0", rcount - r0);
    end
    send(1'b0, 8'h44, 32'h100, 32'h0);
    drain();
    checks++;
    if (last_data !== 32'h0) begin
      errors++;
      $display("FAIL cleared_array got %h expected 00000000", last_data);
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
